// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers the displayed hex value from a time-multiplexed,
// active-low 7-segment bus. A digit is captured after its select and pattern
// have been seen unchanged for STABLE_CYCLES consecutive samples. A frame is
// reported once every digit has been captured at least once.
// Optional feature macro: SEG_READER_DP_EN (capture the decimal point). When it
// is undefined, dp_flags is tied low and segments[7] is ignored entirely.

module seg_scan_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_DIGITS-1:0]         anodes,
  input  logic [7:0]                    segments,
  output logic                          digit_valid,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_valid,
  output logic [4*NUM_DIGITS-1:0]       value,
  output logic [NUM_DIGITS-1:0]         dp_flags,
  output logic [NUM_DIGITS-1:0]         err_flags
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
`ifdef SEG_READER_DP_EN
  localparam logic [7:0] SegCmpMask = 8'hFF;
`else
  localparam logic [7:0] SegCmpMask = 8'h7F;
`endif

  typedef enum logic [1:0] {StWait, StSettle, StHeld} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   smp_an_q;
  logic [7:0]              smp_seg_q;
  logic [NUM_DIGITS-1:0]   an_act;
  logic                    legal, same, capture, frame_fire;
  logic [IdxW-1:0]         sel_idx;
  logic [3:0]              dec_nib;
  logic                    dec_err;
  logic [4*NUM_DIGITS-1:0] work_val;
  logic [NUM_DIGITS-1:0]   work_err;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;

  // Select legality, stability against the previous sample, and selected index
  always_comb begin
    an_act  = ~anodes;
    legal   = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0);
    same    = (anodes == smp_an_q) && (((segments ^ smp_seg_q) & SegCmpMask) == 8'h00);
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!anodes[i]) sel_idx = IdxW'(i);
    end
  end

  // Inverse 7-segment decode of the g..a pattern
  always_comb begin
    dec_nib = 4'h0;
    dec_err = 1'b0;
    case (segments[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h18: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h27: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_err = 1'b1;
    endcase
  end

  // FSM state and stability counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StWait;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: cnt counts consecutive identical samples of the current pattern
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWait: begin
        if (legal) begin
          state_d = StSettle;
          cnt_d   = CntOne;
        end
      end
      StSettle: begin
        if (same) begin
          if (cnt_q == CntLast) begin
            state_d = StHeld;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (legal) begin
          cnt_d = CntOne;
        end else begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StHeld: begin
        if (!same) begin
          state_d = legal ? StSettle : StWait;
          cnt_d   = legal ? CntOne : '0;
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: capture on the sample that completes the stable run
  always_comb begin
    capture    = (state_q == StSettle) && same && (cnt_q == CntLast);
    frame_fire = &mask_q;
  end

  // Capture mask: a full mask publishes the frame and restarts collection
  always_comb begin
    mask_d = frame_fire ? '0 : mask_q;
    if (capture) mask_d[sel_idx] = 1'b1;
  end

  // Input sample, working entries, and published outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      smp_an_q    <= '0;
      smp_seg_q   <= '0;
      digit_valid <= 1'b0;
      digit_idx   <= '0;
      frame_valid <= 1'b0;
      work_val    <= '0;
      work_err    <= '0;
      mask_q      <= '0;
      value       <= '0;
      err_flags   <= '0;
    end else begin
      smp_an_q    <= anodes;
      smp_seg_q   <= segments;
      digit_valid <= capture;
      frame_valid <= frame_fire;
      mask_q      <= mask_d;
      if (capture) begin
        digit_idx                     <= sel_idx;
        work_val[{sel_idx, 2'b00} +: 4] <= dec_nib;
        work_err[sel_idx]             <= dec_err;
      end
      if (frame_fire) begin
        value     <= work_val;
        err_flags <= work_err;
      end
    end
  end

`ifdef SEG_READER_DP_EN
  logic [NUM_DIGITS-1:0] work_dp;

  // Decimal point capture and publication
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      work_dp  <= '0;
      dp_flags <= '0;
    end else begin
      if (capture) work_dp[sel_idx] <= ~segments[7];
      if (frame_fire) dp_flags <= work_dp;
    end
  end
`else
  assign dp_flags = '0;
`endif

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: randomized and directed stimulus for seg_scan_reader,
// checked against a run-length reference model of the display bus.

module tb_seg_scan_reader;

  localparam int ND     = 4;
  localparam int STABLE = 4;
`ifdef SEG_READER_DP_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
  localparam logic [3:0] T3_DP    = 4'b0100;
`else
  localparam logic [7:0] CMP_MASK = 8'h7F;
  localparam logic [3:0] T3_DP    = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  anodes;
  logic [7:0]  segments;
  logic        digit_valid;
  logic [1:0]  digit_idx;
  logic        frame_valid;
  logic [15:0] value;
  logic [3:0]  dp_flags;
  logic [3:0]  err_flags;

  seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .anodes      (anodes),
    .segments    (segments),
    .digit_valid (digit_valid),
    .digit_idx   (digit_idx),
    .frame_valid (frame_valid),
    .value       (value),
    .dp_flags    (dp_flags),
    .err_flags   (err_flags)
  );

  always #5 clk = ~clk;

  logic [6:0] pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state
  logic [11:0] prev_key;
  bit          prev_ok;
  int          run;
  logic [15:0] m_work_val, m_value;
  logic [3:0]  m_work_dp, m_work_err, m_mask, m_dp, m_err;
  logic [1:0]  m_idx;
  bit          m_pend;

  // Observation counters
  int obs_dv, obs_fv, step_no, last_dv_step;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] nib,
                                     output logic err);
    nib = 4'h0;
    err = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (pat_tab[k] == p) begin
        nib = 4'(k);
        err = 1'b0;
      end
    end
  endfunction

  task automatic model_reset();
    prev_ok    = 1'b0;
    prev_key   = '0;
    run        = 0;
    m_work_val = '0;
    m_work_dp  = '0;
    m_work_err = '0;
    m_mask     = '0;
    m_value    = '0;
    m_dp       = '0;
    m_err      = '0;
    m_idx      = '0;
    m_pend     = 1'b0;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    model_reset();
    for (int c = 0; c < n; c++) begin
      anodes   = 4'($urandom);
      segments = 8'($urandom);
      @(posedge clk);
      #1;
      check_eq("rst_dv", digit_valid, 0);
      check_eq("rst_fv", frame_valid, 0);
      check_eq("rst_idx", digit_idx, 0);
      check_eq("rst_value", value, 0);
      check_eq("rst_dp", dp_flags, 0);
      check_eq("rst_err", err_flags, 0);
    end
    resetn = 1'b1;
  endtask

  // One clock of stimulus; the model predicts what the bus rules imply for it
  task automatic step(input logic [3:0] an, input logic [7:0] seg);
    logic [11:0] key;
    logic        legal, exp_dv, exp_fv, err;
    logic [3:0]  nib;
    int          idx;
    anodes   = an;
    segments = seg;
    @(posedge clk);
    #1;
    step_no++;
    key = {an, seg & CMP_MASK};
    if (prev_ok && key == prev_key) run++;
    else run = 1;
    prev_key = key;
    prev_ok  = 1'b1;
    legal    = ($countones(~an) == 1);
    exp_fv   = m_pend;
    if (m_pend) begin
      m_value = m_work_val;
      m_dp    = m_work_dp;
      m_err   = m_work_err;
      m_mask  = '0;
      m_pend  = 1'b0;
    end
    exp_dv = legal && (run == STABLE);
    if (exp_dv) begin
      idx = 0;
      for (int k = 0; k < ND; k++) if (!an[k]) idx = k;
      ref_decode(seg[6:0], nib, err);
      m_work_val[idx*4 +: 4] = nib;
      m_work_err[idx] = err;
`ifdef SEG_READER_DP_EN
      m_work_dp[idx] = ~seg[7];
`endif
      m_mask[idx] = 1'b1;
      m_idx = 2'(idx);
      if (m_mask == 4'hF) m_pend = 1'b1;
    end
    if (digit_valid) begin
      obs_dv++;
      last_dv_step = step_no;
    end
    if (frame_valid) obs_fv++;
    check_eq("digit_valid", digit_valid, exp_dv);
    check_eq("frame_valid", frame_valid, exp_fv);
    if (exp_dv) check_eq("digit_idx", digit_idx, m_idx);
    check_eq("value", value, m_value);
    check_eq("dp_flags", dp_flags, m_dp);
    check_eq("err_flags", err_flags, m_err);
  endtask

  task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
    for (int c = 0; c < n; c++) step(an, seg);
  endtask

  function automatic logic [3:0] sel(input int d);
    logic [3:0] a;
    a    = 4'hF;
    a[d] = 1'b0;
    return a;
  endfunction

  initial begin
    int dv0, fv0, st0;
    resetn   = 1'b0;
    anodes   = 4'hF;
    segments = 8'hFF;
    obs_dv = 0; obs_fv = 0; step_no = 0; last_dv_step = 0;

    // 1: reset with busy inputs, then only a 4-sample stable legal pattern captures
    do_reset(5);
    dv0 = obs_dv;
    hold(4'b0000, 8'hC0, 3);
    hold(4'b1101, 8'hC0, 3);
    hold(4'b1011, 8'hF9, 4);
    check_eq("t1_dv_count", obs_dv - dv0, 1);

    // 2: single held digit captures once, 4 cycles after first appearance
    do_reset(2);
    dv0 = obs_dv; fv0 = obs_fv; st0 = step_no;
    hold(4'b1110, 8'hC0, 100);
    check_eq("t2_dv_count", obs_dv - dv0, 1);
    check_eq("t2_latency", last_dv_step - st0, 4);
    check_eq("t2_fv_count", obs_fv - fv0, 0);

    // 3: full frame
    do_reset(2);
    fv0 = obs_fv;
    hold(sel(0), 8'hF9, 6);
    hold(sel(1), 8'h88, 6);
    hold(sel(2), 8'h12, 6);
    hold(sel(3), 8'h8E, 6);
    hold(4'hF, 8'hFF, 3);
    check_eq("t3_fv_count", obs_fv - fv0, 1);
    check_eq("t3_value", value, 16'hF5A1);
    check_eq("t3_dp", dp_flags, T3_DP);
    check_eq("t3_err", err_flags, 0);

    // 4: short glitch is dropped, illegal select never captures
    do_reset(2);
    dv0 = obs_dv;
    hold(sel(1), 8'hA4, 3);
    hold(sel(1), 8'hB0, 8);
    check_eq("t4_dv_count", obs_dv - dv0, 1);
    check_eq("t4_idx", digit_idx, 1);
    dv0 = obs_dv;
    hold(4'b1100, 8'hC0, 20);
    check_eq("t4_illegal_dv", obs_dv - dv0, 0);

    // 5: unknown patterns flag errors and decode to zero
    do_reset(2);
    hold(sel(0), 8'hFF, 5);
    hold(sel(1), 8'hAA, 5);
    hold(sel(2), 8'hC0, 5);
    hold(sel(3), 8'hC0, 5);
    hold(4'hF, 8'hFF, 2);
    check_eq("t5_err", err_flags, 4'b0011);
    check_eq("t5_low_nibbles", value[7:0], 0);

    // 6: reset mid-settle discards partial work
    do_reset(2);
    hold(sel(0), 8'hF9, 2);
    do_reset(2);
    fv0 = obs_fv;
    hold(sel(0), 8'h92, 5);
    hold(sel(1), 8'h82, 6);
    hold(sel(2), 8'hF8, 7);
    hold(sel(3), 8'h80, 8);
    hold(4'hF, 8'hFF, 2);
    check_eq("t6_fv_count", obs_fv - fv0, 1);
    check_eq("t6_value", value, 16'h8765);
`ifndef SEG_READER_DP_EN
    dv0 = obs_dv;
    hold(sel(2), 8'hC0, 6);
    for (int c = 0; c < 20; c++) step(sel(2), (c % 2 == 0) ? 8'h40 : 8'hC0);
    check_eq("t6_dp_toggle_dv", obs_dv - dv0, 1);
`endif

    // Randomized bus traffic
    do_reset(2);
    for (int r = 0; r < 400; r++) begin
      logic [3:0] an;
      logic [7:0] sg;
      int         len;
      len = int'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) an = 4'($urandom);
      else an = sel(int'($urandom_range(0, ND - 1)));
      if ($urandom_range(0, 4) == 0) sg = 8'($urandom);
      else sg = {1'($urandom), pat_tab[$urandom_range(0, 15)]};
      hold(an, sg, len);
      if ($urandom_range(0, 99) == 0) do_reset(1);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
